get_stream_fifo: RTL and testbench
==================================

# get_stream_fifo

Elastic buffer on the input stream path of the accelerator: it accepts 64-bit AXI-Stream beats from the DMA and re-presents them to the `S_AXIS_*` slave port of `top`. It absorbs backpressure while the core's `get_enable` gating holds `S_AXIS_TREADY` low. It counts beats per frame and checks each frame length against a programmed expected count.

## Interface
Parameters:
- DEPTH, 16 — FIFO entries; power of two, minimum 4.
- CNT_W, 20 — width of the beat counters; matches the 20-bit addressing used by the core.

Ports:
- AXIS_ACLK  in  1  — single clock for all logic.
- AXIS_ARESETN  in  1  — asynchronous, active-low reset.
- clear  in  1  — synchronous flush; driven from `~run`.
- exp_beats  in  CNT_W  — expected beats per frame; sampled on the first beat of each frame.
- S_AXIS_TVALID / S_AXIS_TREADY  in / out  1 / 1  — upstream (DMA) handshake.
- S_AXIS_TDATA  in  64  — upstream data.
- S_AXIS_TSTRB  in  8  — upstream byte strobes.
- S_AXIS_TLAST  in  1  — upstream end-of-frame marker.
- M_AXIS_TVALID / M_AXIS_TREADY  out / in  1 / 1  — downstream handshake toward `top`.
- M_AXIS_TDATA  out  64  — downstream data.
- M_AXIS_TSTRB  out  8  — downstream byte strobes.
- M_AXIS_TLAST  out  1  — downstream end-of-frame marker.
- level  out  $clog2(DEPTH)+1  — current occupancy.
- beat_cnt  out  CNT_W  — beats accepted in the current frame.
- frame_done  out  1  — one-cycle pulse when a TLAST beat is accepted upstream.
- len_err  out  1  — sticky frame-length mismatch flag.

## Operation
- Storage: circular buffer of {TLAST, TSTRB, TDATA}, 73 bits per entry.
  - Write and read pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - Pointers wrap naturally at 2·DEPTH.
- Push: occurs when `S_AXIS_TVALID & S_AXIS_TREADY`.
  - `S_AXIS_TREADY = ~full`, derived from registers only; there is no combinational path from `M_AXIS_TREADY`.
- Pop: occurs when `M_AXIS_TVALID & M_AXIS_TREADY`.
  - The output is first-word-fall-through: head entry is on `M_AXIS_T*` whenever `M_AXIS_TVALID` is high.
  - `M_AXIS_TVALID = ~empty`.
- Simultaneous push and pop: level is unchanged; both pointers advance.
- Full: push is blocked by the ready signal. Pop still proceeds, and ready rises the following cycle.
- Empty: `M_AXIS_TVALID` stays low; TDATA is don't-care.
- Frame counter:
  - `beat_cnt` increments on each push.
  - On a push with TLAST=1, it reloads to 0 and `frame_done` pulses.
  - It saturates at 2^CNT_W−1.
- Length check: on the first push of a frame (`beat_cnt==0`), `exp_beats` is latched. `len_err` sets if either:
  - TLAST arrives on beat k with k ≠ the latched value, or
  - the beat count reaches the latched value without TLAST.

  `len_err` clears only on reset or `clear`.
- `clear`:
  - Pointers, level, `beat_cnt` and `len_err` go to 0.
  - A push or pop in the same cycle is discarded.
  - `S_AXIS_TREADY` stays low while `clear` is high.
- Reset mid-frame has the same effect as `clear`, applied asynchronously.

## Timing
- Reset values:
  - `S_AXIS_TREADY`=0 during reset; it rises in the first cycle after deassertion.
  - `M_AXIS_TVALID`=0, `M_AXIS_TLAST`=0, `level`=0, `beat_cnt`=0, `frame_done`=0, `len_err`=0.
  - `M_AXIS_TDATA`/`M_AXIS_TSTRB` reset to 0.
- Latency: a beat pushed at edge N is visible on `M_AXIS_T*` with TVALID=1 after edge N (cycle N+1) when the FIFO was empty.
- Throughput: one beat per cycle sustained at any level between 1 and DEPTH−1.
- `frame_done` and `len_err` assert in the cycle after the offending or last push edge.
- `level` is registered and updates in the cycle after the push or pop edge.

## Configuration
- GET_STREAM_FIFO_LEN_CHECK_EN
  - Defined: `exp_beats` latch, comparison and `len_err` logic are compiled in.
  - Undefined: `len_err` is tied to 0, `exp_beats` is ignored, and `beat_cnt` and `frame_done` remain.

## Structure
- Shared package `hpu_pkg` holds:
  - `STREAM_DW` = 64 and `STREAM_SW` = 8.
  - Packed struct `stream_beat_t` {last, strb, data}.
- One sub-module, `get_fifo_mem`: a DEPTH×73 simple dual-port register array with write port and asynchronous read port.
- Pointer, handshake, counter and check logic live in `get_stream_fifo`.

## Test plan
- Reset, then 1 beat (TDATA=64'h1, TLAST=1, exp_beats=1) with M_TREADY=1 → M_TVALID for 1 cycle, data 64'h1, frame_done pulse, len_err=0.
- M_TREADY=0, 20 beats offered with DEPTH=16 → 16 accepted, S_TREADY=0, level=16. Then release M_TREADY → all 20 emerge in order with no gaps after the first.
- M_TREADY=1 and S_TVALID=1 continuous for 300 beats, TLAST on beat 300, exp_beats=300 → one beat per cycle, level ≤1, frame_done once, len_err=0.
- exp_beats=8, TLAST on beat 5 → len_err=1 after beat 5. Next frame correct → len_err stays 1 until `clear`.
- Frame of 10 beats with `clear` asserted after beat 4 while 3 entries are held → level=0, M_TVALID=0, beat_cnt=0 the next cycle, and the held beats are never emitted.
- Without GET_STREAM_FIFO_LEN_CHECK_EN, repeat the mismatch case → len_err stays 0 and frame_done still pulses.

Source files
------------

// File: rtl/hpu_pkg.sv
// Shared stream types for the accelerator's DMA-facing datapaths.
// One beat is {last, strb, data}; 73 bits for the 64-bit stream.
package hpu_pkg;
  localparam int STREAM_DW = 64;
  localparam int STREAM_SW = 8;

  typedef struct packed {
    logic                 last;
    logic [STREAM_SW-1:0] strb;
    logic [STREAM_DW-1:0] data;
  } stream_beat_t;

  localparam int BEAT_W = $bits(stream_beat_t);
endpackage

// File: rtl/get_stream_fifo_if.sv
// AXI-Stream style handshake bundle; master drives payload and valid,
// slave drives ready.
interface get_stream_fifo_if;
  import hpu_pkg::*;

  logic                 TVALID;
  logic                 TREADY;
  logic [STREAM_DW-1:0] TDATA;
  logic [STREAM_SW-1:0] TSTRB;
  logic                 TLAST;

  modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);
endinterface

// File: rtl/get_stream_fifo_mem.sv
// DEPTH-entry beat storage: one synchronous write port, one asynchronous
// read port so the FIFO head falls through without a register stage.
module get_fifo_mem
  import hpu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  stream_beat_t             wr_beat,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output stream_beat_t             rd_beat
);

  stream_beat_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_beat;
  end

  assign rd_beat = mem[rd_addr];

endmodule

// File: rtl/get_stream_fifo.sv
// Elastic FWFT buffer on the DMA input stream with per-frame beat counting.
// Frame-length checking is compiled in only with GET_STREAM_FIFO_LEN_CHECK_EN.
module get_stream_fifo
  import hpu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 20
) (
  input  logic                     AXIS_ACLK,
  input  logic                     AXIS_ARESETN,
  input  logic                     clear,
  input  logic [CNT_W-1:0]         exp_beats,
  get_stream_fifo_if.slave         S_AXIS,
  get_stream_fifo_if.master        M_AXIS,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         beat_cnt,
  output logic                     frame_done,
  output logic                     len_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rdy_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  stream_beat_t  in_beat;
  stream_beat_t  head;

  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  // rdy_q holds ready low until the first edge after reset release.
  assign S_AXIS.TREADY = rdy_q & ~full & ~clear;
  assign push          = S_AXIS.TVALID & S_AXIS.TREADY;
  assign pop           = M_AXIS.TVALID & M_AXIS.TREADY & ~clear;

  assign in_beat.last = S_AXIS.TLAST;
  assign in_beat.strb = S_AXIS.TSTRB;
  assign in_beat.data = S_AXIS.TDATA;

  get_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (AXIS_ACLK),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_beat (in_beat),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_beat (head)
  );

  // Payload is masked while empty so stale or unwritten entries never show.
  assign M_AXIS.TVALID = ~empty;
  assign M_AXIS.TDATA  = empty ? '0 : head.data;
  assign M_AXIS.TSTRB  = empty ? '0 : head.strb;
  assign M_AXIS.TLAST  = empty ? 1'b0 : head.last;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      rdy_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  logic [CNT_W:0] beat_nxt;
  assign beat_nxt = {1'b0, beat_cnt} + 1'b1;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      beat_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= push & S_AXIS.TLAST;
      if (clear) begin
        beat_cnt <= '0;
      end else if (push) begin
        if (S_AXIS.TLAST)      beat_cnt <= '0;
        else if (~&beat_cnt)   beat_cnt <= beat_nxt[CNT_W-1:0];
      end
    end
  end

`ifdef GET_STREAM_FIFO_LEN_CHECK_EN
  logic [CNT_W-1:0] exp_q;
  logic [CNT_W-1:0] exp_eff;
  logic             err_q;
  logic             mismatch;

  // The first beat of a frame compares against the live input it latches.
  assign exp_eff  = (beat_cnt == '0) ? exp_beats : exp_q;
  assign mismatch = S_AXIS.TLAST ? (beat_nxt != {1'b0, exp_eff})
                                 : (beat_nxt == {1'b0, exp_eff});

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else if (clear) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else if (push) begin
      if (beat_cnt == '0) exp_q <= exp_beats;
      if (mismatch)       err_q <= 1'b1;
    end
  end

  assign len_err = err_q;
`else
  logic unused_exp;
  assign unused_exp = ^exp_beats;
  assign len_err    = 1'b0;
`endif

endmodule

// File: tb/tb_get_stream_fifo.sv
// Directed bench for get_stream_fifo: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops and compares every output handshake.
module tb_get_stream_fifo;
  import hpu_pkg::*;

`ifdef GET_STREAM_FIFO_LEN_CHECK_EN
  localparam logic LEN_CHK = 1'b1;
`else
  localparam logic LEN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [19:0] exp_beats = '0;
  logic [4:0]  level;
  logic [19:0] beat_cnt;
  logic        frame_done;
  logic        len_err;

  get_stream_fifo_if s_if ();
  get_stream_fifo_if m_if ();

  get_stream_fifo #(.DEPTH(16), .CNT_W(20)) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .clear        (clear),
    .exp_beats    (exp_beats),
    .S_AXIS       (s_if),
    .M_AXIS       (m_if),
    .level        (level),
    .beat_cnt     (beat_cnt),
    .frame_done   (frame_done),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  int           n_acc = 0;
  int           pop_count = 0;
  int           cyc = 0;
  int           fd_cnt = 0;
  int           max_lvl = 0;
  bit           track = 0;
  stream_beat_t exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    stream_beat_t b;
    bit done = 0;
    b.last = l; b.strb = s; b.data = d;
    s_if.TVALID = 1'b1;
    s_if.TDATA  = d;
    s_if.TSTRB  = s;
    s_if.TLAST  = l;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (s_if.TREADY) begin
        @(posedge clk);
        #1;
        exp_q.push_back(b);
        n_acc++;
        done = 1;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: beat %h not accepted, required within 200 cycles", d);
    end
    s_if.TVALID = 1'b0;
  endtask

  // Scoreboard monitor: every downstream handshake consumes one expected beat.
  always @(negedge clk) begin
    if (rst_n && !clear && m_if.TVALID && m_if.TREADY) begin
      stream_beat_t act;
      act.last = m_if.TLAST; act.strb = m_if.TSTRB; act.data = m_if.TDATA;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got %h, required no output", act);
      end else begin
        chk("out_beat", act, exp_q.pop_front());
      end
      pop_count++;
    end
  end

  always @(negedge clk) begin
    if (track) begin
      if (frame_done) fd_cnt++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c0, c1, p0, a0;
    s_if.TVALID = 1'b0; s_if.TDATA = '0; s_if.TSTRB = '0; s_if.TLAST = 1'b0;
    m_if.TREADY = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_s_tready", s_if.TREADY, 0);
    chk("rst_m_tvalid", m_if.TVALID, 0);
    chk("rst_m_tlast",  m_if.TLAST, 0);
    chk("rst_m_tdata",  m_if.TDATA, 0);
    chk("rst_m_tstrb",  m_if.TSTRB, 0);
    chk("rst_level",    level, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_len_err",  len_err, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", s_if.TREADY, 1);

    // Single-beat frame
    @(posedge clk); #1;
    m_if.TREADY = 1'b1;
    exp_beats = 20'd1;
    send_beat(64'h1, 8'hFF, 1'b1);
    @(negedge clk);
    chk("single_tvalid", m_if.TVALID, 1);
    chk("single_frame_done", frame_done, 1);
    chk("single_len_err", len_err, 0);
    chk("single_beat_cnt", beat_cnt, 0);
    @(negedge clk);
    chk("single_tvalid_drop", m_if.TVALID, 0);
    chk("single_fd_drop", frame_done, 0);
    chk("single_level", level, 0);

    // Fill past DEPTH with downstream stalled, then drain
    @(posedge clk); #1;
    m_if.TREADY = 1'b0;
    exp_beats = 20'd20;
    a0 = n_acc;
    fork
      begin
        for (int i = 0; i < 20; i++) send_beat(64'h2000 + 64'(i), 8'hFF, i == 19);
      end
    join_none
    repeat (30) @(negedge clk);
    #1;
    chk("fill_level", level, 16);
    chk("fill_s_tready", s_if.TREADY, 0);
    chk("fill_accepted", n_acc - a0, 16);
    @(posedge clk); #1;
    m_if.TREADY = 1'b1;
    p0 = pop_count;
    repeat (20) @(negedge clk);
    #1;
    chk("drain_no_gaps", pop_count - p0, 20);
    @(negedge clk);
    chk("drain_empty", m_if.TVALID, 0);
    chk("drain_len_err", len_err, 0);

    // 300-beat streaming frame at full rate
    @(posedge clk); #1;
    exp_beats = 20'd300;
    fd_cnt = 0; max_lvl = 0; track = 1;
    c0 = cyc;
    for (int i = 0; i < 300; i++) send_beat(64'h3000_0000 + 64'(i), 8'(i), i == 299);
    c1 = cyc;
    repeat (3) @(negedge clk);
    track = 0;
    chk("stream_cycles", c1 - c0, 300);
    chk("stream_max_level", max_lvl, 1);
    chk("stream_frame_done", fd_cnt, 1);
    chk("stream_len_err", len_err, 0);

    // Short frame: exp 8, TLAST on beat 5; exp_beats changes after beat 1
    @(posedge clk); #1;
    exp_beats = 20'd8;
    send_beat(64'h4001, 8'h01, 1'b0);
    exp_beats = 20'd5;
    send_beat(64'h4002, 8'h03, 1'b0);
    send_beat(64'h4003, 8'h07, 1'b0);
    send_beat(64'h4004, 8'h0F, 1'b0);
    @(negedge clk);
    chk("short_pre_err", len_err, 0);
    chk("short_beat_cnt", beat_cnt, 4);
    @(posedge clk); #1;
    send_beat(64'h4005, 8'h1F, 1'b1);
    @(negedge clk);
    chk("short_len_err", len_err, LEN_CHK);
    chk("short_frame_done", frame_done, 1);
    @(posedge clk); #1;
    exp_beats = 20'd3;
    send_beat(64'h4101, 8'hFF, 1'b0);
    send_beat(64'h4102, 8'hFF, 1'b0);
    send_beat(64'h4103, 8'hFF, 1'b1);
    @(negedge clk);
    chk("sticky_len_err", len_err, LEN_CHK);
    chk("sticky_frame_done", frame_done, 1);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_len_err", len_err, 0);

    // Long frame: count reaches exp_beats=2 without TLAST
    @(posedge clk); #1;
    exp_beats = 20'd2;
    send_beat(64'h4201, 8'hAA, 1'b0);
    send_beat(64'h4202, 8'h55, 1'b0);
    @(negedge clk);
    chk("long_len_err", len_err, LEN_CHK);
    @(posedge clk); #1;
    send_beat(64'h4203, 8'hF0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;

    // Clear mid-frame with 3 beats held
    exp_beats = 20'd10;
    m_if.TREADY = 1'b1;
    send_beat(64'h5001, 8'hFF, 1'b0);
    send_beat(64'h5002, 8'hFF, 1'b0);
    m_if.TREADY = 1'b0;
    send_beat(64'h5003, 8'hFF, 1'b0);
    send_beat(64'h5004, 8'hFF, 1'b0);
    @(negedge clk);
    chk("held_level", level, 3);
    chk("held_beat_cnt", beat_cnt, 4);
    @(posedge clk); #1;
    clear = 1'b1;
    m_if.TREADY = 1'b1;
    exp_q.delete();
    s_if.TVALID = 1'b1; s_if.TDATA = 64'hDEAD; s_if.TSTRB = 8'hFF; s_if.TLAST = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    s_if.TVALID = 1'b0;
    @(negedge clk);
    chk("flush_level", level, 0);
    chk("flush_tvalid", m_if.TVALID, 0);
    chk("flush_beat_cnt", beat_cnt, 0);
    @(posedge clk); #1;
    exp_beats = 20'd6;
    for (int i = 5; i <= 10; i++) send_beat(64'h5000 + 64'(i), 8'hFF, i == 10);
    repeat (5) @(negedge clk);
    chk("post_flush_len_err", len_err, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
